serial_bridge: RTL
==================

# serial_bridge

Parametrised host-to-serial bridge: the next generation of the serial connection block. It replaces the strobe-driven external UART with an internal transmitter and receiver, each buffered by a FIFO, with configurable data width, bit period and depth. The host sees a two-register window (data, status) selected by `index` and accessed with `mode`. It sits between the switch/LED or CPU-side bus and the board's RS-232 pins.

## Interface
- `DATA_W`, 8: bits per serial character and data register width.
- `DIV`, 434: clock cycles per serial bit; minimum 4.
- `DEPTH`, 16: entries per TX and RX FIFO; power of two, minimum 2.
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-low.
- `mode` in 2: 00 idle, 01 write, 10 read, 11 reserved (no-op). Non-idle for exactly one cycle per access.
- `index` in 3: 3'b110 data register, 3'b111 status register; other values are no-op.
- `wdata` in DATA_W: write data.
- `rdata` out DATA_W: registered read data.
- `status` out 4: {rx_avail, tx_space, rx_overrun, rx_err}.
- `u_rxd` in 1: serial input, asynchronous.
- `u_txd` out 1: serial output, idle high.

## Operation
- Write to data (mode 01, index 110): push `wdata` into the TX FIFO. If the FIFO is full, the write is dropped and state is unchanged.
- Read from data (mode 10, index 110): pop the RX FIFO head into `rdata`. If the FIFO is empty, `rdata` loads 0 and the pointers do not move.
- Read from status (mode 10, index 111): `rdata` loads {0…, status}. Clears the sticky bits `rx_overrun` and `rx_err`.
- Writes to status are ignored.
- `status` is live and updates every cycle:
  - `rx_avail` = RX FIFO not empty.
  - `tx_space` = TX FIFO not full.
  - `rx_overrun` is sticky: set when a received character finds the RX FIFO full. The character is discarded.
  - `rx_err` is sticky: set on a bad stop bit, and on a parity error when parity is enabled.
- TX FSM, states IDLE → START → DATA → (PARITY) → STOP → IDLE:
  - Leaves IDLE when the TX FIFO is non-empty, popping the head.
  - Each state lasts DIV cycles. Data is sent LSB first.
  - After STOP, goes directly to START if the FIFO is non-empty (back-to-back characters, no idle gap).
- RX FSM, states IDLE → START → DATA → (PARITY) → STOP → IDLE:
  - `u_rxd` passes through a 2-flop synchroniser.
  - A low level in IDLE enters START. The line is sampled at DIV/2; if high, the start is treated as a glitch and the FSM returns to IDLE.
  - Each following bit is sampled DIV cycles after the previous sample.
  - STOP sample low: set `rx_err`, still push the character, and wait for the line to go high before returning to IDLE.
- Width rules:
  - Bit counter is $clog2(DATA_W+1) bits; baud counter is $clog2(DIV) bits.
  - FIFO pointers are $clog2(DEPTH)+1 bits. Full = MSBs differ and the other bits are equal.
- Reset:
  - `u_txd`=1, `rdata`=0, `status`=4'b0100.
  - Both FIFOs empty, both FSMs in IDLE, sticky bits clear.
  - Reset mid-character aborts it immediately; `u_txd` returns high on the next cycle.

## Timing
- Read latency 1: `rdata` is valid the cycle after the access and holds until the next read.
- Write-to-start-bit: `u_txd` falls 2 cycles after the write when TX is idle (FIFO push, then FSM pop).
- RX push occurs on the cycle after the stop-bit sample. `rx_avail` rises on the following cycle.
- Same-cycle host pop and RX push on a full FIFO: the pop is applied first, the push succeeds, and no overrun is flagged.
- Same-cycle status read and new error event: the set wins, and the bit stays 1.
- Character time = (DATA_W+2) × DIV cycles, or (DATA_W+3) × DIV cycles with parity.

## Configuration
- `SERIAL_BRIDGE_PARITY_EN`:
  - Defined: an even-parity bit is inserted after the data bits on TX. RX checks it, and a mismatch sets `rx_err`; the character is still pushed.
  - Undefined: no parity state exists in either FSM. Frame is 8N1 for DATA_W=8.

## Structure
- Shared package `serial_pkg` holds:
  - Mode constants `MODE_IDLE`, `MODE_WRITE`, `MODE_READ`.
  - Index constants `IDX_DATA`=3'b110 and `IDX_STATUS`=3'b111.
  - The TX/RX FSM state typedef.
- One sub-module, `serial_fifo` (parameters WIDTH, DEPTH; push/pop/full/empty), instantiated twice.
- TX and RX FSMs stay inline in `serial_bridge`.

## Test plan
- DIV=4, write 8'hA5 → `u_txd` waveform is 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles, first falling edge 2 cycles after the write.
- Loop `u_txd` to `u_rxd` and write 8'h3C, 8'hC3 back-to-back → two data reads return 8'h3C then 8'hC3; `status` ends at 4'b0100.
- Drive DEPTH+1 characters into RX with no reads → `status[1]`=1 after the last one. A status read returns rx_overrun=1 and clears it; the first DEPTH characters read back intact.
- Drive a character with the stop bit low → `rx_err`=1, the character is still readable, and RX recovers on the next valid frame.
- Assert `rst` low mid-TX-character → `u_txd`=1 and `status`=4'b0100 the next cycle. A read of the empty RX FIFO returns 0.
- With `SERIAL_BRIDGE_PARITY_EN`, inject 8'h01 with parity bit 0 → `rx_err`=1; with parity bit 1 → no error.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for serial_bridge: host access encodings and the TX/RX FSM state type.
// The parity state exists only when SERIAL_BRIDGE_PARITY_EN is defined.
package serial_pkg;

  localparam logic [1:0] MODE_IDLE  = 2'b00;
  localparam logic [1:0] MODE_WRITE = 2'b01;
  localparam logic [1:0] MODE_READ  = 2'b10;

  localparam logic [2:0] IDX_DATA   = 3'b110;
  localparam logic [2:0] IDX_STATUS = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef SERIAL_BRIDGE_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } serial_state_e;

endpackage

// File: rtl/serial_fifo.sv
// Synchronous FIFO with show-ahead head output; a pop in the same cycle makes room
// for a push into a full FIFO.
module serial_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // The extra pointer MSB tells a full FIFO from an empty one.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage has no reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/serial_bridge.sv
// Host-to-serial bridge: data/status register window over buffered UART TX and RX.
// Define SERIAL_BRIDGE_PARITY_EN to add an even-parity bit after the data bits.
module serial_bridge
  import serial_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DIV    = 434,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic [2:0]        index,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic [3:0]        status,
  input  logic              u_rxd,
  output logic              u_txd
);

  localparam int CW = $clog2(DIV);
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] BAUD_HALF = CW'(DIV / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);

  logic wr_data, rd_data, rd_stat;
  logic tx_push, tx_pop, tx_full, tx_empty;
  logic rx_push, rx_full, rx_empty;
  logic [DATA_W-1:0] tx_head, rx_head;
  logic rx_overrun, rx_err, rx_done, rx_err_set;

  assign wr_data = (mode == MODE_WRITE) && (index == IDX_DATA);
  assign rd_data = (mode == MODE_READ)  && (index == IDX_DATA);
  assign rd_stat = (mode == MODE_READ)  && (index == IDX_STATUS);
  assign tx_push = wr_data && !tx_full;
  assign status  = {!rx_empty, !tx_full, rx_overrun, rx_err};

  serial_fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .din(wdata),
    .dout(tx_head), .full(tx_full), .empty(tx_empty)
  );

  logic [DATA_W-1:0] rx_shift;

  serial_fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .pop(rd_data), .din(rx_shift),
    .dout(rx_head), .full(rx_full), .empty(rx_empty)
  );

  // Sticky bits: a set in the same cycle as a status read wins over the clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata      <= '0;
      rx_overrun <= 1'b0;
      rx_err     <= 1'b0;
    end else begin
      if (rd_data)      rdata <= rx_empty ? '0 : rx_head;
      else if (rd_stat) rdata <= DATA_W'(status);
      rx_overrun <= (rx_overrun && !rd_stat) || (rx_push && rx_full && !rd_data);
      rx_err     <= (rx_err && !rd_stat) || rx_err_set;
    end
  end

  // ---------------- transmitter ----------------
  serial_state_e     tx_state, tx_state_n;
  logic [CW-1:0]     tx_cnt, tx_cnt_n;
  logic [BW-1:0]     tx_bits, tx_bits_n;
  logic [DATA_W-1:0] tx_shift, tx_shift_n;
  logic              tx_line, tx_line_n;
`ifdef SERIAL_BRIDGE_PARITY_EN
  logic              tx_par, tx_par_n;
`endif

  assign u_txd = tx_line;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned and infers a latch.
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_bits_n  = tx_bits;
    tx_shift_n = tx_shift;
    tx_line_n  = tx_line;
    tx_pop     = 1'b0;
`ifdef SERIAL_BRIDGE_PARITY_EN
    tx_par_n   = tx_par;
`endif
    case (tx_state)
      ST_IDLE: begin
        tx_line_n = 1'b1;
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_n = tx_head;
          tx_cnt_n   = '0;
          tx_line_n  = 1'b0;
          tx_state_n = ST_START;
`ifdef SERIAL_BRIDGE_PARITY_EN
          tx_par_n   = ^tx_head;
`endif
        end
      end
      ST_START: begin
        if (tx_cnt == BAUD_LAST) begin
          tx_cnt_n   = '0;
          tx_bits_n  = '0;
          tx_line_n  = tx_shift[0];
          tx_state_n = ST_DATA;
        end else tx_cnt_n = tx_cnt + 1'b1;
      end
      ST_DATA: begin
        if (tx_cnt == BAUD_LAST) begin
          tx_cnt_n = '0;
          if (tx_bits == BIT_LAST) begin
`ifdef SERIAL_BRIDGE_PARITY_EN
            tx_line_n  = tx_par;
            tx_state_n = ST_PARITY;
`else
            tx_line_n  = 1'b1;
            tx_state_n = ST_STOP;
`endif
          end else begin
            tx_bits_n  = tx_bits + 1'b1;
            tx_shift_n = tx_shift >> 1;
            tx_line_n  = tx_shift[1];
          end
        end else tx_cnt_n = tx_cnt + 1'b1;
      end
`ifdef SERIAL_BRIDGE_PARITY_EN
      ST_PARITY: begin
        if (tx_cnt == BAUD_LAST) begin
          tx_cnt_n   = '0;
          tx_line_n  = 1'b1;
          tx_state_n = ST_STOP;
        end else tx_cnt_n = tx_cnt + 1'b1;
      end
`endif
      ST_STOP: begin
        // Chain straight into the next start bit when more data is queued.
        if (tx_cnt == BAUD_LAST) begin
          tx_cnt_n = '0;
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_shift_n = tx_head;
            tx_line_n  = 1'b0;
            tx_state_n = ST_START;
`ifdef SERIAL_BRIDGE_PARITY_EN
            tx_par_n   = ^tx_head;
`endif
          end else begin
            tx_line_n  = 1'b1;
            tx_state_n = ST_IDLE;
          end
        end else tx_cnt_n = tx_cnt + 1'b1;
      end
      default: tx_state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_state <= ST_IDLE;
      tx_cnt   <= '0;
      tx_bits  <= '0;
      tx_shift <= '0;
      tx_line  <= 1'b1;
`ifdef SERIAL_BRIDGE_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bits  <= tx_bits_n;
      tx_shift <= tx_shift_n;
      tx_line  <= tx_line_n;
`ifdef SERIAL_BRIDGE_PARITY_EN
      tx_par   <= tx_par_n;
`endif
    end
  end

  // ---------------- receiver ----------------
  serial_state_e     rx_state, rx_state_n;
  logic [CW-1:0]     rx_cnt, rx_cnt_n;
  logic [BW-1:0]     rx_bits, rx_bits_n;
  logic [DATA_W-1:0] rx_shift_n;
  logic              rx_meta, rx_sync;
  logic              rx_wait, rx_wait_n;
`ifdef SERIAL_BRIDGE_PARITY_EN
  logic              rx_par_bad, rx_par_bad_n;
`endif

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_bits_n  = rx_bits;
    rx_shift_n = rx_shift;
    rx_wait_n  = rx_wait;
    rx_done    = 1'b0;
    rx_err_set = 1'b0;
`ifdef SERIAL_BRIDGE_PARITY_EN
    rx_par_bad_n = rx_par_bad;
`endif
    case (rx_state)
      ST_IDLE: begin
        if (!rx_sync) begin
          rx_cnt_n   = '0;
          rx_state_n = ST_START;
        end
      end
      ST_START: begin
        // Mid-bit recheck rejects glitches shorter than half a bit.
        if (rx_cnt == BAUD_HALF) begin
          rx_cnt_n   = '0;
          rx_bits_n  = '0;
          rx_state_n = rx_sync ? ST_IDLE : ST_DATA;
`ifdef SERIAL_BRIDGE_PARITY_EN
          rx_par_bad_n = 1'b0;
`endif
        end else rx_cnt_n = rx_cnt + 1'b1;
      end
      ST_DATA: begin
        if (rx_cnt == BAUD_LAST) begin
          rx_cnt_n   = '0;
          rx_shift_n = {rx_sync, rx_shift[DATA_W-1:1]};
          if (rx_bits == BIT_LAST) begin
`ifdef SERIAL_BRIDGE_PARITY_EN
            rx_state_n = ST_PARITY;
`else
            rx_state_n = ST_STOP;
`endif
          end else rx_bits_n = rx_bits + 1'b1;
        end else rx_cnt_n = rx_cnt + 1'b1;
      end
`ifdef SERIAL_BRIDGE_PARITY_EN
      ST_PARITY: begin
        if (rx_cnt == BAUD_LAST) begin
          rx_cnt_n     = '0;
          rx_par_bad_n = rx_sync ^ (^rx_shift);
          rx_state_n   = ST_STOP;
        end else rx_cnt_n = rx_cnt + 1'b1;
      end
`endif
      ST_STOP: begin
        if (rx_wait) begin
          if (rx_sync) begin
            rx_wait_n  = 1'b0;
            rx_state_n = ST_IDLE;
          end
        end else if (rx_cnt == BAUD_LAST) begin
          rx_cnt_n   = '0;
          rx_done    = 1'b1;
`ifdef SERIAL_BRIDGE_PARITY_EN
          rx_err_set = !rx_sync || rx_par_bad;
`else
          rx_err_set = !rx_sync;
`endif
          if (rx_sync) rx_state_n = ST_IDLE;
          else         rx_wait_n  = 1'b1;
        end else rx_cnt_n = rx_cnt + 1'b1;
      end
      default: rx_state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_state <= ST_IDLE;
      rx_cnt   <= '0;
      rx_bits  <= '0;
      rx_shift <= '0;
      rx_wait  <= 1'b0;
      rx_push  <= 1'b0;
`ifdef SERIAL_BRIDGE_PARITY_EN
      rx_par_bad <= 1'b0;
`endif
    end else begin
      rx_meta  <= u_rxd;
      rx_sync  <= rx_meta;
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bits  <= rx_bits_n;
      rx_shift <= rx_shift_n;
      rx_wait  <= rx_wait_n;
      rx_push  <= rx_done;
`ifdef SERIAL_BRIDGE_PARITY_EN
      rx_par_bad <= rx_par_bad_n;
`endif
    end
  end

endmodule
